ram_loader: RTL
===============

# ram_loader

Program loader sitting directly upstream of the 16-bit program/data RAM. It receives a framed byte stream (length, words, checksum) over a valid/ready interface and writes the words to consecutive RAM addresses from 0. It then reads the image back through the RAM's 1-cycle registered read port and verifies the checksum. While loading or verifying, it holds the CPU off the RAM; otherwise it passes CPU accesses through unchanged.

## Interface
- SIZE, 13, RAM address width.
- DEPTH, 8192, RAM word count; maximum accepted image length.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- i_valid  in  1  a byte is offered on i_byte.
- i_byte  in  8  stream byte.
- o_ready  out  1  loader accepts i_byte this cycle. A byte transfers when i_valid && o_ready.
- i_cpu_we, i_cpu_addr[SIZE-1:0], i_cpu_data[15:0]  in  CPU-side RAM request.
- o_we  out  1  RAM write enable.
- o_addr  out  SIZE  RAM address.
- o_data  out  16  RAM write data.
- i_ram_data  in  16  RAM read data, valid one cycle after the address is presented.
- o_cpu_hold  out  1  high while the loader owns the RAM.
- o_done  out  1  image loaded and verified; sticky until the next i_start.
- o_err  out  1  load failed; sticky until the next i_start.

## Operation
- Frame format:
  - LEN: 2 bytes, N[15:0], high byte first.
  - N data words, each 2 bytes, high byte first.
  - CSUM: 2 bytes, high byte first; CSUM = sum of all words mod 2^16.
- States:
  - IDLE -> LEN_HI on i_start.
  - LEN_HI -> LEN_LO on byte accept.
  - LEN_LO -> ERR if N > DEPTH; else -> CSUM_HI if N == 0; else -> DATA_HI.
  - DATA_HI -> DATA_LO on byte accept.
  - DATA_LO -> DATA_HI on byte accept; after the Nth word, -> CSUM_HI.
  - CSUM_HI -> CSUM_LO on byte accept.
  - CSUM_LO -> ERR if the running sum differs from CSUM; else -> VERIFY.
  - VERIFY -> DONE or ERR.
  - DONE / ERR -> LEN_HI on i_start.
- o_ready = 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO.
- Write path:
  - Accepting the low byte of word k registers o_we=1, o_addr=k, o_data={hi,lo} for exactly one cycle.
  - The word counter is SIZE+1 bits, so N == DEPTH is legal and the last write goes to address DEPTH-1 without wrap.
- Running sum: 16-bit, wraps, cleared on i_start.
- VERIFY:
  - Drives o_addr = 0..N-1 on consecutive cycles with o_we=0.
  - Adds i_ram_data one cycle after each address into a second 16-bit sum.
  - After the last data returns, the next cycle goes to DONE if that sum equals CSUM, else to ERR.
  - N == 0 goes through VERIFY with zero reads.
- Ownership:
  - o_cpu_hold = 1 in every state except IDLE, DONE and ERR.
  - When not held, o_we/o_addr/o_data equal the i_cpu_* inputs combinationally.
  - When held, they come from the loader's registers.
- i_start in any busy state is ignored. i_valid in a non-ready state is ignored and no byte is consumed.
- ERR: no further RAM writes. Words already written stay in RAM.

## Timing
- Reset values: state IDLE, o_ready 0, o_cpu_hold 0, o_done 0, o_err 0. Loader-side o_we, o_addr and o_data registers are 0.
- Reset asserted mid-load: immediately returns to IDLE and releases the RAM. Partial RAM contents are not cleared.
- i_start at edge t gives o_ready=1 and o_cpu_hold=1 from t+1.
- Throughput is one byte per cycle. The RAM write appears one cycle after the low-byte accept.
- VERIFY duration is N+2 cycles from entry to DONE/ERR: N addresses, 1 cycle of read latency, 1 compare cycle.
- i_start coincident with a byte offer in IDLE: the byte is not consumed.

## Structure
- Package ram_loader_pkg holds:
  - the state enum;
  - localparams for the byte order and the frame field count.
- Sub-module ram_loader_csum: a 16-bit clearable wrapping accumulator with enable, instantiated twice (receive sum and verify sum).
- The ownership mux and the read-back pipeline stay inline.

## Test plan
- Load N=3, words 0x1234, 0xABCD, 0x0001, CSUM 0xBE02, sent back-to-back. Required: writes at addresses 0,1,2 with those values, VERIFY of 5 cycles, o_done=1, o_err=0, o_cpu_hold drops.
- Same frame with CSUM 0xBE03. Required: ERR after CSUM_LO, no VERIFY reads, o_err=1, RAM still holds the 3 words.
- LEN 0x2001 (N > 8192). Required: ERR straight after LEN_LO, zero writes. Then LEN 0x0000 with CSUM 0x0000: DONE.
- Random i_valid gaps and CPU writes presented while held. Required: no CPU write reaches the RAM during the load; after DONE, a CPU write to 0x0005 passes through on the same cycle.
- rst pulsed low during DATA_LO of word 2. Required: all outputs at reset values. A new i_start with a full frame then completes with o_done=1.
- N=8192 words. Required: last write at address 0x1FFF, no wrap to 0, DONE.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the framed program loader.
package ram_loader_pkg;

    localparam int DEF_SIZE      = 13;
    localparam int DEF_DEPTH     = 8192;
    localparam bit HI_BYTE_FIRST = 1'b1;
    localparam int FRAME_FIELDS  = 3;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LEN_HI  = 4'd1,
        ST_LEN_LO  = 4'd2,
        ST_DATA_HI = 4'd3,
        ST_DATA_LO = 4'd4,
        ST_CSUM_HI = 4'd5,
        ST_CSUM_LO = 4'd6,
        ST_VERIFY  = 4'd7,
        ST_DONE    = 4'd8,
        ST_ERR     = 4'd9
    } state_t;

    // Assemble a 16-bit field from two bytes in stream order.
    function automatic logic [15:0] join_bytes(input logic [7:0] first_b, input logic [7:0] second_b);
        return HI_BYTE_FIRST ? {first_b, second_b} : {second_b, first_b};
    endfunction

endpackage

// File: rtl/ram_loader_csum.sv
// 16-bit wrapping accumulator with synchronous clear (priority) and enable.
module ram_loader_csum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic [15:0] din,
    output logic [15:0] sum
);

    logic [15:0] sum_r;

    // Accumulate enabled words, wrapping modulo 2^16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= 16'd0;
        end else if (clear) begin
            sum_r <= 16'd0;
        end else if (en) begin
            sum_r <= sum_r + din;
        end else begin
            sum_r <= sum_r;
        end
    end

    assign sum = sum_r;

endmodule

// File: rtl/ram_loader.sv
// Framed byte-stream RAM loader with checksum read-back verification and
// CPU ownership multiplexing of the RAM port.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_valid,
    input  logic [7:0]      i_byte,
    output logic            o_ready,
    input  logic            i_cpu_we,
    input  logic [SIZE-1:0] i_cpu_addr,
    input  logic [15:0]     i_cpu_data,
    output logic            o_we,
    output logic [SIZE-1:0] o_addr,
    output logic [15:0]     o_data,
    input  logic [15:0]     i_ram_data,
    output logic            o_cpu_hold,
    output logic            o_done,
    output logic            o_err
);

    localparam logic [SIZE:0] CNT_ONE = {{SIZE{1'b0}}, 1'b1};

    state_t          state_r;
    logic            ready_r, hold_r, done_r, err_r;
    logic            we_r, rd_valid_r;
    logic [SIZE-1:0] addr_r;
    logic [15:0]     data_r, csum_r;
    logic [7:0]      hi_r;
    logic [SIZE:0]   len_r, wcnt_r, vcnt_r;

    logic            accept_s, start_s, rx_en_s;
    logic [15:0]     word_s, rx_sum_s, ver_sum_s;
    logic [SIZE:0]   wcnt_next_s, vcnt_next_s;

    assign accept_s    = i_valid && ready_r;
    assign word_s      = join_bytes(hi_r, i_byte);
    assign start_s     = i_start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));
    assign rx_en_s     = accept_s && (state_r == ST_DATA_LO);
    assign wcnt_next_s = wcnt_r + CNT_ONE;
    assign vcnt_next_s = vcnt_r + CNT_ONE;

    ram_loader_csum u_rx_sum (
        .clk   (clk),
        .rst_n (rst),
        .clear (start_s),
        .en    (rx_en_s),
        .din   (word_s),
        .sum   (rx_sum_s)
    );

    // Read data arrives one cycle after its address, hence the delayed enable.
    ram_loader_csum u_ver_sum (
        .clk   (clk),
        .rst_n (rst),
        .clear (start_s),
        .en    (rd_valid_r),
        .din   (i_ram_data),
        .sum   (ver_sum_s)
    );

    // Frame parser, write sequencer and read-back verifier with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            ready_r    <= 1'b0;
            hold_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            we_r       <= 1'b0;
            rd_valid_r <= 1'b0;
            addr_r     <= {SIZE{1'b0}};
            data_r     <= 16'd0;
            csum_r     <= 16'd0;
            hi_r       <= 8'd0;
            len_r      <= {(SIZE+1){1'b0}};
            wcnt_r     <= {(SIZE+1){1'b0}};
            vcnt_r     <= {(SIZE+1){1'b0}};
        end else begin
            we_r       <= 1'b0;
            rd_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (i_start) begin
                        state_r <= ST_LEN_HI;
                        ready_r <= 1'b1;
                        hold_r  <= 1'b1;
                        done_r  <= 1'b0;
                        err_r   <= 1'b0;
                        wcnt_r  <= {(SIZE+1){1'b0}};
                        len_r   <= {(SIZE+1){1'b0}};
                    end
                end
                ST_LEN_HI: begin
                    if (accept_s) begin
                        hi_r    <= i_byte;
                        state_r <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept_s) begin
                        len_r <= word_s[SIZE:0];
                        if (word_s > 16'(DEPTH)) begin
                            state_r <= ST_ERR;
                            ready_r <= 1'b0;
                            hold_r  <= 1'b0;
                            err_r   <= 1'b1;
                        end else if (word_s == 16'd0) begin
                            state_r <= ST_CSUM_HI;
                        end else begin
                            state_r <= ST_DATA_HI;
                        end
                    end
                end
                ST_DATA_HI: begin
                    if (accept_s) begin
                        hi_r    <= i_byte;
                        state_r <= ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    if (accept_s) begin
                        we_r    <= 1'b1;
                        addr_r  <= wcnt_r[SIZE-1:0];
                        data_r  <= word_s;
                        wcnt_r  <= wcnt_next_s;
                        state_r <= (wcnt_next_s == len_r) ? ST_CSUM_HI : ST_DATA_HI;
                    end
                end
                ST_CSUM_HI: begin
                    if (accept_s) begin
                        hi_r    <= i_byte;
                        state_r <= ST_CSUM_LO;
                    end
                end
                ST_CSUM_LO: begin
                    if (accept_s) begin
                        csum_r  <= word_s;
                        ready_r <= 1'b0;
                        if (rx_sum_s != word_s) begin
                            state_r <= ST_ERR;
                            hold_r  <= 1'b0;
                            err_r   <= 1'b1;
                        end else begin
                            state_r <= ST_VERIFY;
                            vcnt_r  <= {(SIZE+1){1'b0}};
                            addr_r  <= {SIZE{1'b0}};
                        end
                    end
                end
                ST_VERIFY: begin
                    // vcnt_r counts cycles in VERIFY: addresses 0..N-1, then latency, then compare.
                    vcnt_r     <= vcnt_next_s;
                    rd_valid_r <= (vcnt_r < len_r);
                    if (vcnt_next_s < len_r) begin
                        addr_r <= vcnt_next_s[SIZE-1:0];
                    end
                    if (vcnt_r == (len_r + CNT_ONE)) begin
                        hold_r <= 1'b0;
                        if (ver_sum_s == csum_r) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_ERR;
                            err_r   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    hold_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready    = ready_r;
    assign o_cpu_hold = hold_r;
    assign o_done     = done_r;
    assign o_err      = err_r;
    assign o_we       = hold_r ? we_r   : i_cpu_we;
    assign o_addr     = hold_r ? addr_r : i_cpu_addr;
    assign o_data     = hold_r ? data_r : i_cpu_data;

endmodule
